// File: rtl/axi_ram_decoder.sv
// axi_ram_decoder: AXI4 slave RAM model, one word-addressed RAM per bank.
// Define AXI_RAM_RANGE_CHECK_EN to flag indices >= MEM_DEPTH (power of two) as SLVERR.
module axi_ram_decoder #(
   parameter int AXI_DATA_WIDTH = 512,
   parameter int AXI_ADDR_WIDTH = 48,
   parameter int AXI_TID_WIDTH  = 8,
   parameter int AXI_NUM_BANKS  = 1,
   parameter int MEM_DEPTH      = 4096
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      m_axi_awvalid [AXI_NUM_BANKS],
   output logic                      m_axi_awready [AXI_NUM_BANKS],
   input  logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr  [AXI_NUM_BANKS],
   input  logic [AXI_TID_WIDTH-1:0]  m_axi_awid    [AXI_NUM_BANKS],
   input  logic [7:0]                m_axi_awlen   [AXI_NUM_BANKS],
   input  logic [2:0]                m_axi_awsize  [AXI_NUM_BANKS],
   input  logic [1:0]                m_axi_awburst [AXI_NUM_BANKS],
   input  logic [1:0]                m_axi_awlock  [AXI_NUM_BANKS],
   input  logic [3:0]                m_axi_awcache [AXI_NUM_BANKS],
   input  logic [2:0]                m_axi_awprot  [AXI_NUM_BANKS],
   input  logic                      m_axi_wvalid  [AXI_NUM_BANKS],
   output logic                      m_axi_wready  [AXI_NUM_BANKS],
   input  logic [AXI_DATA_WIDTH-1:0] m_axi_wdata   [AXI_NUM_BANKS],
   input  logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb [AXI_NUM_BANKS],
   input  logic                      m_axi_wlast   [AXI_NUM_BANKS],
   output logic                      m_axi_bvalid  [AXI_NUM_BANKS],
   output logic [AXI_TID_WIDTH-1:0]  m_axi_bid     [AXI_NUM_BANKS],
   output logic [1:0]                m_axi_bresp   [AXI_NUM_BANKS],
   input  logic                      m_axi_bready  [AXI_NUM_BANKS],
   input  logic                      m_axi_arvalid [AXI_NUM_BANKS],
   output logic                      m_axi_arready [AXI_NUM_BANKS],
   input  logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr  [AXI_NUM_BANKS],
   input  logic [AXI_TID_WIDTH-1:0]  m_axi_arid    [AXI_NUM_BANKS],
   input  logic [7:0]                m_axi_arlen   [AXI_NUM_BANKS],
   input  logic [2:0]                m_axi_arsize  [AXI_NUM_BANKS],
   input  logic [1:0]                m_axi_arburst [AXI_NUM_BANKS],
   input  logic [1:0]                m_axi_arlock  [AXI_NUM_BANKS],
   input  logic [3:0]                m_axi_arcache [AXI_NUM_BANKS],
   input  logic [2:0]                m_axi_arprot  [AXI_NUM_BANKS],
   output logic                      m_axi_rvalid  [AXI_NUM_BANKS],
   output logic [AXI_DATA_WIDTH-1:0] m_axi_rdata   [AXI_NUM_BANKS],
   output logic                      m_axi_rlast   [AXI_NUM_BANKS],
   output logic [AXI_TID_WIDTH-1:0]  m_axi_rid     [AXI_NUM_BANKS],
   output logic [1:0]                m_axi_rresp   [AXI_NUM_BANKS],
   input  logic                      m_axi_rready  [AXI_NUM_BANKS]
);
   localparam int DW = AXI_DATA_WIDTH;
   localparam int SB = DW / 8;
   localparam int SH = $clog2(SB);
   localparam int XW = AXI_ADDR_WIDTH - SH;
   localparam int IW = $clog2(MEM_DEPTH);
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] FIXED  = 2'b00;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   logic          mem_we    [AXI_NUM_BANKS];
   logic [IW-1:0] mem_waddr [AXI_NUM_BANKS];
   logic [IW-1:0] mem_raddr [AXI_NUM_BANKS];
   logic [DW-1:0] mem_rdata [AXI_NUM_BANKS];

   function automatic logic [XW-1:0] step(input logic [XW-1:0] idx,
                                          input logic [1:0] burst);
      return (burst == FIXED) ? idx : idx + XW'(1);
   endfunction

   // Bank 0 storage lives in a fixed scope so benches can reach ram0.mem.
   if (AXI_NUM_BANKS > 0) begin : ram0
      logic [DW-1:0] mem [0:MEM_DEPTH-1];
      always_ff @(posedge clk) begin
         if (mem_we[0]) begin
            for (int i = 0; i < SB; i++) begin
               if (m_axi_wstrb[0][i])
                  mem[mem_waddr[0]][i*8 +: 8] <= m_axi_wdata[0][i*8 +: 8];
            end
         end
      end
      assign mem_rdata[0] = mem[mem_raddr[0]];
   end

   for (genvar b = 1; b < AXI_NUM_BANKS; b++) begin : g_ram
      logic [DW-1:0] mem [0:MEM_DEPTH-1];
      always_ff @(posedge clk) begin
         if (mem_we[b]) begin
            for (int i = 0; i < SB; i++) begin
               if (m_axi_wstrb[b][i])
                  mem[mem_waddr[b]][i*8 +: 8] <= m_axi_wdata[b][i*8 +: 8];
            end
         end
      end
      assign mem_rdata[b] = mem[mem_raddr[b]];
   end

   for (genvar b = 0; b < AXI_NUM_BANKS; b++) begin : g_bank
      wstate_t       wstate;
      rstate_t       rstate;
      logic [XW-1:0] aw_word, ar_word, widx, ridx;
      logic [7:0]    wlen, wcnt, rlen, rcnt;
      logic [1:0]    wburst, rburst;
      logic          werr, w_fire, w_oor, a_oor, n_oor;
      logic          unused_bits;

      assign aw_word = m_axi_awaddr[b][AXI_ADDR_WIDTH-1:SH];
      assign ar_word = m_axi_araddr[b][AXI_ADDR_WIDTH-1:SH];
      assign w_fire  = m_axi_wvalid[b] && m_axi_wready[b];
      assign mem_we[b]    = w_fire && !w_oor;
      assign mem_waddr[b] = widx[IW-1:0];
      assign mem_raddr[b] = (rstate == R_IDLE) ? ar_word[IW-1:0]
                                               : ridx[IW-1:0];
`ifdef AXI_RAM_RANGE_CHECK_EN
      assign w_oor = widx >= XW'(MEM_DEPTH);
      assign a_oor = ar_word >= XW'(MEM_DEPTH);
      assign n_oor = ridx >= XW'(MEM_DEPTH);
`else
      assign w_oor = 1'b0;
      assign a_oor = 1'b0;
      assign n_oor = 1'b0;
`endif
      assign unused_bits = ^{m_axi_awaddr[b][SH-1:0], m_axi_awsize[b],
                             m_axi_awlock[b], m_axi_awcache[b],
                             m_axi_awprot[b], m_axi_araddr[b][SH-1:0],
                             m_axi_arsize[b], m_axi_arlock[b],
                             m_axi_arcache[b], m_axi_arprot[b],
                             m_axi_wlast[b]};

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            wstate           <= W_IDLE;
            m_axi_awready[b] <= 1'b0;
            m_axi_wready[b]  <= 1'b0;
            m_axi_bvalid[b]  <= 1'b0;
            m_axi_bid[b]     <= '0;
            m_axi_bresp[b]   <= OKAY;
            widx   <= '0;
            wlen   <= '0;
            wcnt   <= '0;
            wburst <= '0;
            werr   <= 1'b0;
         end else begin
            unique case (wstate)
               W_IDLE: begin
                  m_axi_awready[b] <= 1'b1;
                  if (m_axi_awvalid[b] && m_axi_awready[b]) begin
                     m_axi_awready[b] <= 1'b0;
                     m_axi_wready[b]  <= 1'b1;
                     m_axi_bid[b]     <= m_axi_awid[b];
                     widx   <= aw_word;
                     wlen   <= m_axi_awlen[b];
                     wburst <= m_axi_awburst[b];
                     wcnt   <= '0;
                     werr   <= 1'b0;
                     wstate <= W_DATA;
                  end
               end
               W_DATA: begin
                  if (w_fire) begin
                     widx <= step(widx, wburst);
                     wcnt <= wcnt + 8'd1;
                     if (w_oor) werr <= 1'b1;
                     if (wcnt == wlen) begin
                        m_axi_wready[b] <= 1'b0;
                        m_axi_bvalid[b] <= 1'b1;
                        m_axi_bresp[b]  <= (werr || w_oor) ? SLVERR : OKAY;
                        wstate <= W_RESP;
                     end
                  end
               end
               W_RESP: begin
                  if (m_axi_bready[b]) begin
                     m_axi_bvalid[b]  <= 1'b0;
                     m_axi_awready[b] <= 1'b1;
                     wstate <= W_IDLE;
                  end
               end
               default: wstate <= W_IDLE;
            endcase
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            rstate           <= R_IDLE;
            m_axi_arready[b] <= 1'b0;
            m_axi_rvalid[b]  <= 1'b0;
            m_axi_rlast[b]   <= 1'b0;
            m_axi_rid[b]     <= '0;
            m_axi_rresp[b]   <= OKAY;
            m_axi_rdata[b]   <= '0;
            ridx   <= '0;
            rlen   <= '0;
            rcnt   <= '0;
            rburst <= '0;
         end else begin
            unique case (rstate)
               R_IDLE: begin
                  m_axi_arready[b] <= 1'b1;
                  if (m_axi_arvalid[b] && m_axi_arready[b]) begin
                     m_axi_arready[b] <= 1'b0;
                     m_axi_rvalid[b]  <= 1'b1;
                     m_axi_rid[b]     <= m_axi_arid[b];
                     m_axi_rlast[b]   <= (m_axi_arlen[b] == 8'd0);
                     m_axi_rdata[b]   <= a_oor ? '0 : mem_rdata[b];
                     m_axi_rresp[b]   <= a_oor ? SLVERR : OKAY;
                     ridx   <= step(ar_word, m_axi_arburst[b]);
                     rburst <= m_axi_arburst[b];
                     rlen   <= m_axi_arlen[b];
                     rcnt   <= '0;
                     rstate <= R_DATA;
                  end
               end
               R_DATA: begin
                  if (m_axi_rready[b]) begin
                     if (m_axi_rlast[b]) begin
                        m_axi_rvalid[b]  <= 1'b0;
                        m_axi_rlast[b]   <= 1'b0;
                        m_axi_arready[b] <= 1'b1;
                        rstate <= R_IDLE;
                     end else begin
                        m_axi_rdata[b] <= n_oor ? '0 : mem_rdata[b];
                        m_axi_rresp[b] <= n_oor ? SLVERR : OKAY;
                        m_axi_rlast[b] <= (rcnt + 8'd1 == rlen);
                        ridx <= step(ridx, rburst);
                        rcnt <= rcnt + 8'd1;
                     end
                  end
               end
               default: rstate <= R_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_axi_ram_decoder.sv
// Self-checking bench for axi_ram_decoder: directed table, corner sequences,
// and randomized bursts against a flat-array memory model.
`timescale 1ns/1ps
module tb_axi_ram_decoder;
   localparam int DW = 512, AW = 48, TW = 8, NB = 1, DEPTH = 4096;
   localparam int SB = DW / 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic          m_axi_awvalid [NB];
   logic          m_axi_awready [NB];
   logic [AW-1:0] m_axi_awaddr  [NB];
   logic [TW-1:0] m_axi_awid    [NB];
   logic [7:0]    m_axi_awlen   [NB];
   logic [2:0]    m_axi_awsize  [NB];
   logic [1:0]    m_axi_awburst [NB];
   logic [1:0]    m_axi_awlock  [NB];
   logic [3:0]    m_axi_awcache [NB];
   logic [2:0]    m_axi_awprot  [NB];
   logic          m_axi_wvalid  [NB];
   logic          m_axi_wready  [NB];
   logic [DW-1:0] m_axi_wdata   [NB];
   logic [SB-1:0] m_axi_wstrb   [NB];
   logic          m_axi_wlast   [NB];
   logic          m_axi_bvalid  [NB];
   logic [TW-1:0] m_axi_bid     [NB];
   logic [1:0]    m_axi_bresp   [NB];
   logic          m_axi_bready  [NB];
   logic          m_axi_arvalid [NB];
   logic          m_axi_arready [NB];
   logic [AW-1:0] m_axi_araddr  [NB];
   logic [TW-1:0] m_axi_arid    [NB];
   logic [7:0]    m_axi_arlen   [NB];
   logic [2:0]    m_axi_arsize  [NB];
   logic [1:0]    m_axi_arburst [NB];
   logic [1:0]    m_axi_arlock  [NB];
   logic [3:0]    m_axi_arcache [NB];
   logic [2:0]    m_axi_arprot  [NB];
   logic          m_axi_rvalid  [NB];
   logic [DW-1:0] m_axi_rdata   [NB];
   logic          m_axi_rlast   [NB];
   logic [TW-1:0] m_axi_rid     [NB];
   logic [1:0]    m_axi_rresp   [NB];
   logic          m_axi_rready  [NB];

   axi_ram_decoder #(
      .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_TID_WIDTH(TW),
      .AXI_NUM_BANKS(NB), .MEM_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid),
      .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
      .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
      .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wlast(m_axi_wlast),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bid(m_axi_bid),
      .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid),
      .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
      .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
      .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata),
      .m_axi_rlast(m_axi_rlast), .m_axi_rid(m_axi_rid),
      .m_axi_rresp(m_axi_rresp), .m_axi_rready(m_axi_rready)
   );

   logic [DW-1:0] model [0:DEPTH-1];
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [TW-1:0] id;
      logic [DW-1:0] data;
      logic [SB-1:0] strb;
      int            idx;
      logic [DW-1:0] exp;
   } tv_t;
   tv_t vec [5];

   task automatic chk(input string name, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rnd_word();
      logic [DW-1:0] v;
      for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [SB-1:0] rnd_strb();
      logic [SB-1:0] s;
      if ($urandom_range(0, 3) == 0) return '1;
      for (int k = 0; k < SB / 32; k++) s[k*32 +: 32] = $urandom;
      return s;
   endfunction

   function automatic bit oor(input longint idx);
`ifdef AXI_RAM_RANGE_CHECK_EN
      return idx >= DEPTH;
`else
      return (idx < 0);
`endif
   endfunction

   function automatic int slot(input longint idx);
      return int'(idx % DEPTH);
   endfunction

   task automatic axi_read(input logic [AW-1:0] addr, input int len,
                           input logic [TW-1:0] id, input logic [1:0] burst,
                           input int stall_beat, input int stall_n);
      longint idx;
      logic [DW-1:0] exp;
      logic [1:0] eresp;
      int n, st;
      idx = longint'(addr >> 6);
      n = 0;
      m_axi_arvalid[0] = 1'b1;
      m_axi_araddr[0]  = addr;
      m_axi_arlen[0]   = len[7:0];
      m_axi_arid[0]    = id;
      m_axi_arburst[0] = burst;
      while (!m_axi_arready[0] && n < 20) begin
         tick;
         n++;
      end
      chk("arready", DW'(m_axi_arready[0]), DW'(1));
      tick;
      m_axi_arvalid[0] = 1'b0;
      for (int k = 0; k <= len; k++) begin
         exp   = oor(idx) ? '0 : model[slot(idx)];
         eresp = oor(idx) ? 2'b10 : 2'b00;
         st    = (k == stall_beat) ? stall_n : 0;
         for (int s = 0; s <= st; s++) begin
            m_axi_rready[0] = (s == st);
            chk($sformatf("rvalid%0d", k), DW'(m_axi_rvalid[0]), DW'(1));
            chk($sformatf("rdata%0d", k), m_axi_rdata[0], exp);
            chk($sformatf("rid%0d", k), DW'(m_axi_rid[0]), DW'(id));
            chk($sformatf("rresp%0d", k), DW'(m_axi_rresp[0]), DW'(eresp));
            chk($sformatf("rlast%0d", k), DW'(m_axi_rlast[0]), DW'(k == len));
            tick;
         end
         if (burst != 2'b00) idx++;
      end
      m_axi_rready[0] = 1'b0;
      chk("r_done", DW'(m_axi_rvalid[0]), DW'(0));
      chk("ar_again", DW'(m_axi_arready[0]), DW'(1));
   endtask

   task automatic axi_write(input logic [AW-1:0] addr, input int len,
                            input logic [TW-1:0] id, input logic [1:0] burst,
                            input bit rnd, input logic [DW-1:0] d0,
                            input logic [SB-1:0] s0, input int abort_beat);
      longint idx;
      bit err;
      int n;
      logic [DW-1:0] d;
      logic [SB-1:0] s;
      idx = longint'(addr >> 6);
      err = 1'b0;
      n = 0;
      m_axi_awvalid[0] = 1'b1;
      m_axi_awaddr[0]  = addr;
      m_axi_awlen[0]   = len[7:0];
      m_axi_awid[0]    = id;
      m_axi_awburst[0] = burst;
      while (!m_axi_awready[0] && n < 20) begin
         tick;
         n++;
      end
      chk("awready", DW'(m_axi_awready[0]), DW'(1));
      tick;
      m_axi_awvalid[0] = 1'b0;
      for (int k = 0; k <= len; k++) begin
         d = rnd ? rnd_word() : d0;
         s = rnd ? rnd_strb() : s0;
         m_axi_wvalid[0] = 1'b0;
         repeat ($urandom_range(0, 1)) tick;
         m_axi_wvalid[0] = 1'b1;
         m_axi_wdata[0]  = d;
         m_axi_wstrb[0]  = s;
         m_axi_wlast[0]  = (k == len);
         chk($sformatf("wready%0d", k), DW'(m_axi_wready[0]), DW'(1));
         if (k == abort_beat) return;
         tick;
         if (oor(idx)) err = 1'b1;
         else begin
            for (int j = 0; j < SB; j++)
               if (s[j]) model[slot(idx)][j*8 +: 8] = d[j*8 +: 8];
         end
         if (burst != 2'b00) idx++;
      end
      m_axi_wvalid[0] = 1'b0;
      m_axi_wlast[0]  = 1'b0;
      repeat ($urandom_range(0, 2)) begin
         chk("bvalid_hold", DW'(m_axi_bvalid[0]), DW'(1));
         tick;
      end
      chk("bvalid", DW'(m_axi_bvalid[0]), DW'(1));
      chk("bid", DW'(m_axi_bid[0]), DW'(id));
      chk("bresp", DW'(m_axi_bresp[0]), DW'(err ? 2'b10 : 2'b00));
      m_axi_bready[0] = 1'b1;
      tick;
      m_axi_bready[0] = 1'b0;
      chk("b_done", DW'(m_axi_bvalid[0]), DW'(0));
      chk("aw_again", DW'(m_axi_awready[0]), DW'(1));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      logic [AW-1:0] a;
      reset = 1'b0;
      m_axi_awvalid[0] = 0; m_axi_awaddr[0] = '0; m_axi_awid[0] = '0;
      m_axi_awlen[0] = '0; m_axi_awsize[0] = 3'd6; m_axi_awburst[0] = 2'b01;
      m_axi_awlock[0] = '0; m_axi_awcache[0] = '0; m_axi_awprot[0] = '0;
      m_axi_wvalid[0] = 0; m_axi_wdata[0] = '0; m_axi_wstrb[0] = '0;
      m_axi_wlast[0] = 0; m_axi_bready[0] = 0;
      m_axi_arvalid[0] = 0; m_axi_araddr[0] = '0; m_axi_arid[0] = '0;
      m_axi_arlen[0] = '0; m_axi_arsize[0] = 3'd6; m_axi_arburst[0] = 2'b01;
      m_axi_arlock[0] = '0; m_axi_arcache[0] = '0; m_axi_arprot[0] = '0;
      m_axi_rready[0] = 0;

      vec[0] = '{48'h10400, 8'd3, DW'(32'hDEADBEEF),
                 {SB{1'b1}}, 'h410, DW'(32'hDEADBEEF)};
      vec[1] = '{48'h10440, 8'd7, DW'(32'h12345678),
                 SB'(4'hF), 'h411, {{(DW-32){1'b1}}, 32'h12345678}};
      vec[2] = '{48'h07000, 8'd1, DW'(32'hCAFEF00D),
                 SB'(0), 'h1C0, {DW{1'b1}}};
      vec[3] = '{48'h12000, 8'hFF, DW'(8'hA5),
                 SB'(1), 'h480, {{(DW-8){1'b1}}, 8'hA5}};
      vec[4] = '{48'h0003F, 8'd2, DW'(16'h55AA),
                 SB'(2), 0, {{(DW-16){1'b1}}, 8'h55, 8'hFF}};

      for (int i = 0; i < DEPTH; i++) begin
         model[i] = rnd_word();
         dut.ram0.mem[i] <= model[i];
      end
      repeat (3) tick;
      chk("rst_awready", DW'(m_axi_awready[0]), DW'(0));
      chk("rst_arready", DW'(m_axi_arready[0]), DW'(0));
      chk("rst_wready", DW'(m_axi_wready[0]), DW'(0));
      chk("rst_bvalid", DW'(m_axi_bvalid[0]), DW'(0));
      chk("rst_rvalid", DW'(m_axi_rvalid[0]), DW'(0));
      chk("rst_rlast", DW'(m_axi_rlast[0]), DW'(0));
      chk("rst_bid", DW'(m_axi_bid[0]), DW'(0));
      chk("rst_rid", DW'(m_axi_rid[0]), DW'(0));
      chk("rst_bresp", DW'(m_axi_bresp[0]), DW'(0));
      chk("rst_rresp", DW'(m_axi_rresp[0]), DW'(0));
      chk("rst_rdata", m_axi_rdata[0], '0);
      reset = 1'b1;
      chk("rel_awready0", DW'(m_axi_awready[0]), DW'(0));
      tick;
      chk("rel_awready1", DW'(m_axi_awready[0]), DW'(1));
      chk("rel_arready1", DW'(m_axi_arready[0]), DW'(1));

      // directed single-beat writes over an all-ones word
      for (int t = 0; t < 5; t++) begin
         model[vec[t].idx] = '1;
         dut.ram0.mem[vec[t].idx] <= '1;
         tick;
         axi_write(vec[t].addr, 0, vec[t].id, 2'b01, 1'b0,
                   vec[t].data, vec[t].strb, -1);
         chk($sformatf("tbl_mem%0d", t), dut.ram0.mem[vec[t].idx], vec[t].exp);
         axi_read(vec[t].addr, 0, vec[t].id, 2'b01, 0, 0);
         chk($sformatf("tbl_rd%0d", t), m_axi_rdata[0], vec[t].exp);
      end

      model['h480] = rnd_word();
      dut.ram0.mem['h480] <= model['h480];
      tick;
      axi_read(48'h12000, 0, 8'd5, 2'b01, 0, 0);

      for (int i = 'h1C0; i <= 'h1C5; i++) begin
         model[i] = rnd_word();
         dut.ram0.mem[i] <= model[i];
      end
      tick;
      axi_read(48'h7000, 5, 8'd9, 2'b01, 2, 3);
      axi_read(48'h7000, 3, 8'd4, 2'b00, 1, 2);
      axi_read(48'h40000, 1, 8'd6, 2'b01, 0, 0);
      axi_write(48'((DEPTH - 2) * 64), 3, 8'd11, 2'b01, 1'b1, '0, '0, -1);
      axi_read(48'((DEPTH - 2) * 64), 3, 8'd12, 2'b01, 0, 0);
      axi_write(48'h8000, 2, 8'd13, 2'b00, 1'b1, '0, '0, -1);
      axi_read(48'h8000, 0, 8'd13, 2'b01, 0, 0);

      // reset lands while beat 3 of an 8-beat write is pending
      axi_write(48'h8000 + 48'h40, 7, 8'd21, 2'b01, 1'b1, '0, '0, 3);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_awready", DW'(m_axi_awready[0]), DW'(0));
      chk("mid_wready", DW'(m_axi_wready[0]), DW'(0));
      chk("mid_bvalid", DW'(m_axi_bvalid[0]), DW'(0));
      chk("mid_arready", DW'(m_axi_arready[0]), DW'(0));
      m_axi_wvalid[0] = 1'b0;
      tick;
      tick;
      reset = 1'b1;
      tick;
      chk("post_awready", DW'(m_axi_awready[0]), DW'(1));
      for (int i = 0; i < 4; i++)
         chk($sformatf("mid_mem%0d", i), dut.ram0.mem['h201 + i], model['h201 + i]);
      axi_write(48'h8000 + 48'h40, 1, 8'd22, 2'b01, 1'b1, '0, '0, -1);
      axi_read(48'h8000 + 48'h40, 3, 8'd23, 2'b01, 1, 1);

      for (int r = 0; r < 60; r++) begin
         a = 48'($urandom_range(0, DEPTH + 15)) * 48'd64
             + 48'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1)
            axi_write(a, $urandom_range(0, 7), 8'($urandom), 2'($urandom_range(0, 2)),
                      1'b1, '0, '0, -1);
         else
            axi_read(a, $urandom_range(0, 7), 8'($urandom), 2'($urandom_range(0, 2)),
                     $urandom_range(0, 7), $urandom_range(0, 3));
      end

      bad = 0;
      for (int i = 0; i < DEPTH; i++)
         if (dut.ram0.mem[i] !== model[i]) bad++;
      chk("mem_sweep", DW'(bad), DW'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
